// File: rtl/mem_port_arbiter.sv
// Arbitrates a single shared memory port between instruction fetch and load/store.
// One access is in flight at a time; hung accesses are aborted after TIMEOUT busy cycles.
module mem_port_arbiter #(
    parameter int size       = 32,
    parameter int TIMEOUT    = 16,
    parameter int MAX_DGRANT = 4
) (
    input  logic            CLK,
    input  logic            RSTa,
    input  logic            if_req,
    input  logic [size-1:0] if_addr,
    output logic [size-1:0] if_rdata,
    output logic            if_valid,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [size-1:0] d_addr,
    input  logic [size-1:0] d_wdata,
    output logic [size-1:0] d_rdata,
    output logic            d_valid,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [size-1:0] mem_addr,
    output logic [size-1:0] mem_wdata,
    input  logic [size-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            busy
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int DG_W = $clog2(MAX_DGRANT + 1);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_IF   = 2'd1;
    localparam logic [1:0] ST_D    = 2'd2;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [DG_W-1:0] DG_MAX  = DG_W'(MAX_DGRANT);

    logic [1:0]      state_q, state_d;
    logic [DG_W-1:0] dgrant_q, dgrant_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [size-1:0] mem_addr_q, mem_addr_d;
    logic [size-1:0] mem_wdata_q, mem_wdata_d;
    logic [size-1:0] if_rdata_q, if_rdata_d;
    logic [size-1:0] d_rdata_q, d_rdata_d;
    logic            if_valid_q, if_valid_d;
    logic            if_err_q, if_err_d;
    logic            d_valid_q, d_valid_d;
    logic            d_err_q, d_err_d;
    logic            busy_q, busy_d;

    // A requester whose completion pulse is showing is still holding last access's req.
    logic if_elig_s, d_elig_s, d_win_s;
    assign if_elig_s = if_req & ~if_valid_q;
    assign d_elig_s  = d_req & ~d_valid_q;
    assign d_win_s   = d_elig_s & (~if_elig_s | (dgrant_q != DG_MAX));

    // Next-state logic: arbitration in IDLE, completion/abort/timeout counting in BUSY.
    always_comb begin
        state_d     = state_q;
        dgrant_d    = dgrant_q;
        to_d        = to_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        if_err_d    = 1'b0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_win_s) begin
                    if (if_elig_s && (dgrant_q != DG_MAX)) begin
                        dgrant_d = dgrant_q + 1'b1;
                    end else begin
                        dgrant_d = dgrant_q;
                    end
                    state_d     = ST_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    to_d        = '0;
                end else if (if_elig_s) begin
                    dgrant_d   = '0;
                    state_d    = ST_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    to_d       = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IF, ST_D: begin
                if (mem_ack || (to_q == TO_LAST)) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    // On abort the port's read data is forced to zero alongside err.
                    if (state_q == ST_IF) begin
                        if_valid_d = 1'b1;
                        if_err_d   = ~mem_ack;
                        if_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        d_valid_d = 1'b1;
                        d_err_d   = ~mem_ack;
                        if (!mem_ack) begin
                            d_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q     <= ST_IDLE;
            dgrant_q    <= '0;
            to_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dgrant_q    <= dgrant_d;
            to_q        <= to_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            if_err_q    <= if_err_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
            busy_q      <= busy_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign if_err    = if_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
endmodule
